array_scheduler: RTL
====================

ARRAY_SCHEDULER -- requirements
Module: array_scheduler

Interface
REQ-001 Parameter N, default 4: systolic array dimension; width of acc_valid_i.
REQ-002 Parameter NREQ, default 2: number of requesters sharing the array.
REQ-003 Parameter LEN_W, default 8: width of tile-count fields.
REQ-004 Parameter TIMEOUT, default 64: maximum RUN cycles per tile before abort.
REQ-005 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_ni  input  1  one clock; reset is synchronous and active-low.
REQ-007 req_valid_i  input  NREQ  per-requester job request.
REQ-008 req_len_i  input  NREQ*LEN_W  per-requester tile count, requester k in bits [k*LEN_W +: LEN_W].
REQ-009 req_ready_o  output  NREQ  one-hot job acceptance; handshake completes on the edge where valid and ready are both high.
REQ-010 grant_o  output  NREQ  one-hot owner of the array (operand mux select); zero when idle.
REQ-011 ctrl_rst_o  output  1  active-high synchronous reset to the array controller.
REQ-012 ctrl_start_o  output  1  single-cycle start pulse to the array controller ready input.
REQ-013 acc_valid_i  input  N  accumulator-row valid flags from the array controller.
REQ-014 done_o  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-015 err_o  output  1  sticky timeout flag, cleared only by reset.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 tile_cnt_o  output  LEN_W  tiles completed in current job.

Function
REQ-018 FSM states: IDLE, CLEAR, START, RUN, NEXT, DONE; all outputs except req_ready_o are registered.
REQ-019 IDLE: req_ready_o combinationally one-hot to the first valid requester at or after rr_ptr (round-robin, wrapping); zero if no valid; on handshake latch winner into grant_o, latch its req_len_i, clear tile_cnt_o, go CLEAR.
REQ-020 Latched length 0: go directly to DONE (no ctrl_start_o issued).
REQ-021 CLEAR: ctrl_rst_o high for exactly 2 cycles, then START.
REQ-022 START: ctrl_start_o high for exactly 1 cycle, then RUN.
REQ-023 RUN: count cycles where any acc_valid_i bit is high (beat count); when beat count reaches N, go NEXT; beats stop counting after N.
REQ-024 RUN: cycle counter starts at 0 on entry; if it reaches TIMEOUT before N beats, set err_o, go DONE (job aborted, remaining tiles skipped).
REQ-025 NEXT: tile_cnt_o increments by 1; if new value equals latched length go DONE, else go CLEAR.
REQ-026 DONE: done_o pulses for 1 cycle on the grant_o bit; rr_ptr set to (granted index + 1) mod NREQ; grant_o cleared on the following cycle; go IDLE.
REQ-027 req_valid_i and req_len_i ignored outside IDLE; a requester dropping valid mid-job has no effect on the job.
REQ-028 tile_cnt_o holds its final value in IDLE until next acceptance.
REQ-029 Per-tile overhead: 2 (CLEAR) + 1 (START) + RUN + 1 (NEXT) cycles; back-to-back jobs separated by one IDLE cycle minimum.

Reset
REQ-030 rst_ni low at an edge: state IDLE, grant_o 0, req_ready_o 0, done_o 0, ctrl_start_o 0, ctrl_rst_o 1, err_o 0, busy_o 0, tile_cnt_o 0, rr_ptr 0, counters 0.
REQ-031 Reset mid-job aborts immediately; no done_o pulse is emitted for the aborted job.
REQ-032 First cycle after reset release: ctrl_rst_o 0, state IDLE.

Verification
REQ-033 Single job: req_valid_i=01, len=2, acc_valid_i gives 4 beats 5 cycles after each start -> 2 ctrl_start_o pulses, tile_cnt_o 1 then 2, done_o=01 once, err_o 0.
REQ-034 Contention: both valid from reset, len=1 each -> requester 0 served first, then 1 (rr_ptr=1), then 0 again if still valid; grant_o never two-hot.
REQ-035 Timeout: len=3, acc_valid_i held 0 -> after 64 RUN cycles err_o=1, done_o pulses, tile_cnt_o=0, FSM returns IDLE, next job accepted.
REQ-036 Zero length: len=0 accepted -> done_o pulse within 2 cycles, no ctrl_start_o, no ctrl_rst_o.
REQ-037 Reset mid-RUN: rst_ni low one cycle during tile 2 of 3 -> all outputs at reset values next cycle, no done_o.
REQ-038 Extra beats: acc_valid_i high 6 cycles in one tile -> exactly one tile counted, counting resumes only after next START.

Source files
------------

// File: rtl/array_scheduler.sv
// Round-robin scheduler sharing one systolic array among NREQ requesters.
// Ports: req_*_i/o job handshake, grant_o/ctrl_*_o array control, acc_valid_i beats, done_o/err_o/busy_o/tile_cnt_o status.
module array_scheduler #(
  parameter int N       = 4,
  parameter int NREQ    = 2,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*LEN_W-1:0] req_len_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [NREQ-1:0]       grant_o,
  output logic                  ctrl_rst_o,
  output logic                  ctrl_start_o,
  input  logic [N-1:0]          acc_valid_i,
  output logic [NREQ-1:0]       done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [LEN_W-1:0]      tile_cnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(N + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_RUN, S_NEXT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] tile_q, tile_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;
  logic             crst_q, cstart_q;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [LEN_W-1:0] win_len;
  int unsigned      k;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(rr_q) + i) % NREQ;
      if (!win_found && req_valid_i[k]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end

  assign win_len = req_len_i[win_idx*LEN_W +: LEN_W];

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == S_IDLE && win_found)
      req_ready_o = NREQ'(1) << win_idx;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    len_d   = len_q;
    tile_d  = tile_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    clr_d   = clr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_ready_o) begin
          grant_d = req_ready_o;
          gidx_d  = win_idx;
          len_d   = win_len;
          tile_d  = '0;
          clr_d   = 1'b0;
          state_d = (win_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        // clr_q toggles so CLEAR lasts two cycles and ends at 0.
        clr_d   = ~clr_q;
        state_d = clr_q ? S_START : S_CLEAR;
      end
      S_START: begin
        beat_d  = '0;
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (|acc_valid_i && beat_q < BW'(N))
          beat_d = beat_q + BW'(1);
        cyc_d = cyc_q + CW'(1);
        if (beat_d == BW'(N)) begin
          state_d = S_NEXT;
        end else if (cyc_d == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_NEXT: begin
        tile_d  = tile_q + LEN_W'(1);
        state_d = (tile_d == len_q) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        rr_d    = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d = (state_d == S_DONE) ? grant_d : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      len_q    <= '0;
      tile_q   <= '0;
      beat_q   <= '0;
      cyc_q    <= '0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
      crst_q   <= 1'b1;
      cstart_q <= 1'b0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      len_q    <= len_d;
      tile_q   <= tile_d;
      beat_q   <= beat_d;
      cyc_q    <= cyc_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
      crst_q   <= (state_d == S_CLEAR);
      cstart_q <= (state_d == S_START);
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign grant_o      = grant_q;
  assign ctrl_rst_o   = crst_q;
  assign ctrl_start_o = cstart_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign tile_cnt_o   = tile_q;

endmodule
